// File: rtl/sha_job_controller.sv
// sha_job_controller: job sequencer in front of sha_block.
// Accepts a job, drives clear/solve/report phases, returns the result.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   job_valid/job_ready      job handshake; job_mid/job_head carry the job
//   abort                    cancel the job in SOLVE or drop it in REPORT
//   midState/headData        registered job data to sha_block
//   loadState/solveEn        sha_block control (Moore, from state)
//   sha_flag/sha_nonce       golden-nonce report from sha_block
//   res_valid/res_ready      result handshake; res_found/res_nonce payload
//   busy                     state is not IDLE
//   found_cnt                wrapping count of delivered found results
module sha_job_controller #(
    parameter int unsigned NCORE        = 2,
    parameter int unsigned MAX_ROUNDS   =
        32'(64'd4294967296 / 64'(NCORE)),
    parameter int unsigned FLAG_HOLDOFF = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_mid,
    input  logic [511:0] job_head,
    input  logic         abort,
    output logic [255:0] midState,
    output logic [511:0] headData,
    output logic         loadState,
    output logic         solveEn,
    input  logic         sha_flag,
    input  logic [31:0]  sha_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_nonce,
    output logic         busy,
    output logic [15:0]  found_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SOLVE  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [31:0] LAST_RND = 32'(MAX_ROUNDS - 1);
    localparam logic [37:0] HOLD     = 38'(FLAG_HOLDOFF);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [5:0]  cyc;
    logic [31:0] rnd;
    logic [37:0] elapsed;

    logic is_idle;
    logic is_load;
    logic is_solve;
    logic is_report;

    logic accept;
    logic flag_ok;
    logic last_cyc;
    logic take_found;
    logic take_exh;
    logic res_done;

    // State decodes drive every Moore output.
    assign is_idle   = (state == S_IDLE);
    assign is_load   = (state == S_LOAD);
    assign is_solve  = (state == S_SOLVE);
    assign is_report = (state == S_REPORT);

    assign job_ready = is_idle && !rst;
    assign busy      = !is_idle;
    assign loadState = is_solve;
    assign solveEn   = is_solve;
    assign res_valid = is_report;

    assign accept = job_valid && job_ready;

    // Elapsed SOLVE cycles: round*64 + cycle, exact in 38 bits.
    assign elapsed  = {rnd, cyc};
    assign flag_ok  = sha_flag && (elapsed >= HOLD);
    assign last_cyc = (rnd == LAST_RND) && (cyc == 6'd63);

    // SOLVE exit priority: abort, then flag, then exhaustion.
    assign take_found = is_solve && !abort && flag_ok;
    assign take_exh   = is_solve && !abort && !flag_ok
                        && last_cyc;

    // Handshake completes only if abort is not dropping it.
    assign res_done = is_report && !abort && res_ready;

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            is_idle: begin
                if (accept)
                    state_nxt = S_LOAD;
            end
            is_load: begin
                state_nxt = S_SOLVE;
            end
            is_solve: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (take_found || take_exh)
                    state_nxt = S_REPORT;
            end
            is_report: begin
                if (abort || res_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Job data is only ever updated at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            midState <= '0;
            headData <= '0;
        end else if (accept) begin
            midState <= job_mid;
            headData <= job_head;
        end
    end

    // Cycle/round counters; cycle wraps 63->0 and bumps the round.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc <= '0;
            rnd <= '0;
        end else if (accept) begin
            cyc <= '0;
            rnd <= '0;
        end else if (is_solve) begin
            cyc <= cyc + 6'd1;
            if (cyc == 6'd63)
                rnd <= rnd + 32'd1;
        end
    end

    // Result payload, held through REPORT until the next exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_found <= 1'b0;
            res_nonce <= '0;
        end else if (take_found) begin
            res_found <= 1'b1;
            res_nonce <= sha_nonce;
        end else if (take_exh) begin
            res_found <= 1'b0;
            res_nonce <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            found_cnt <= '0;
        else if (res_done && res_found)
            found_cnt <= found_cnt + 16'd1;
    end

endmodule
